pkt_fifo_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that merges NUM_PORTS Avalon-ST packet streams into the

---
 rtl/pkt_arb_pkg.sv | 39 +++
 rtl/pkt_fifo_arbiter_rr_pick.sv | 38 +++
 rtl/pkt_fifo_arbiter.sv | 129 ++++++++++++
 tb/tb_pkt_fifo_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
package pkt_arb_pkg;

  localparam int PKT_DATA_W  = 512;
  localparam int PKT_EMPTY_W = 6;
  localparam int RR_MAX      = 8;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // One beat as it sits in the output register.
  typedef struct packed {
    logic [PKT_DATA_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [PKT_EMPTY_W-1:0] empty;
  } pkt_beat_t;

  // Reference round-robin pick: first requester at or after ptr, modulo n.
  // Returns a one-hot grant (zero when nothing requests).
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [2:0] ptr, input int n);
    logic [RR_MAX-1:0] oh;
    logic [2:0]        idx;
    logic              found;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        idx = 3'((int'(ptr) + k) % n);
        if (!found && req[idx]) begin
          oh[idx] = 1'b1;
          found   = 1'b1;
        end
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/pkt_fifo_arbiter_rr_pick.sv
// Round-robin picker: rotate requests by ptr, priority-encode lowest, unrotate.
module rr_pick_nxt #(
  parameter  int NUM_PORTS = 4,
  localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [GW-1:0]        gnt_idx
);

  logic [NUM_PORTS-1:0] rot;
  logic [GW-1:0]        rot_idx;
  logic                 hit;

  function automatic logic [GW-1:0] wrap(input int v);
    return GW'(v % NUM_PORTS);
  endfunction

  // Rotate so ptr lands on bit 0, take the lowest set bit, map it back.
  always_comb begin
    rot     = '0;
    gnt     = '0;
    rot_idx = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) rot[i] = req[wrap(i + int'(ptr))];
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rot[i] && !hit) begin
        rot_idx = GW'(i);
        hit     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++)
      gnt[wrap(i + int'(ptr))] = hit && (GW'(i) == rot_idx);
    gnt_idx = wrap(int'(rot_idx) + int'(ptr));
  end

endmodule

// File: rtl/pkt_fifo_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS Avalon-ST streams into one
// FIFO input. A grant is held SOP..EOP; new packets wait while almost_full.
// DATA_W / EMPTY_W must match the widths of pkt_beat_t in the package.
module pkt_fifo_arbiter
  import pkt_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int DATA_W    = PKT_DATA_W,
  parameter  int EMPTY_W   = PKT_EMPTY_W,
  parameter  int CNT_W     = 32,
  localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                         in_clk,
  input  logic                         rst_l,
  input  logic [NUM_PORTS*DATA_W-1:0]  req_data,
  input  logic [NUM_PORTS-1:0]         req_valid,
  output logic [NUM_PORTS-1:0]         req_ready,
  input  logic [NUM_PORTS-1:0]         req_sop,
  input  logic [NUM_PORTS-1:0]         req_eop,
  input  logic [NUM_PORTS*EMPTY_W-1:0] req_empty,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [EMPTY_W-1:0]           out_empty,
  input  logic                         fifo_almost_full,
  output logic [GW-1:0]                grant_port,
  output logic [NUM_PORTS*CNT_W-1:0]   pkt_count,
  output logic                         proto_err
);

  arb_state_t                          state, state_nxt;
  logic [GW-1:0]                       grant, rr_ptr, pick_idx;
  logic [NUM_PORTS-1:0]                cand, pick_oh;
  logic                                first_beat, slot_free, do_grant, take, take_eop;
  pkt_beat_t                           out_q;
  logic                                out_v;
  logic [NUM_PORTS-1:0][CNT_W-1:0]     cnt;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    data_v;
  logic [NUM_PORTS-1:0][EMPTY_W-1:0]   empty_v;

  assign data_v    = req_data;
  assign empty_v   = req_empty;
  assign slot_free = !out_v || out_ready;
  assign cand      = req_valid & req_sop;
  assign do_grant  = (state == IDLE) && !fifo_almost_full && (|pick_oh) && slot_free;
  assign take      = (state == LOCKED) && req_valid[grant] && slot_free;
  assign take_eop  = take && req_eop[grant];

  rr_pick_nxt #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req     (cand),
    .ptr     (rr_ptr),
    .gnt     (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Only the locked port sees ready, and only when the output slot can take a beat.
  always_comb begin
    req_ready = '0;
    if (state == LOCKED && slot_free) req_ready[grant] = 1'b1;
  end

  // Next state: lock on a grant, release on an accepted EOP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_grant) state_nxt = LOCKED;
      LOCKED:  if (take_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge in_clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant, round-robin pointer and sticky protocol-error tracking.
  always_ff @(posedge in_clk or negedge rst_l) begin
    if (!rst_l) begin
      grant      <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (do_grant) begin
        grant      <= pick_idx;
        first_beat <= 1'b1;
      end
      if (take) first_beat <= 1'b0;
      if (take_eop)
        rr_ptr <= (grant == GW'(NUM_PORTS - 1)) ? '0 : grant + GW'(1);
      if ((state == IDLE && |(req_valid & ~req_sop)) ||
          (take && req_sop[grant] && !first_beat))
        proto_err <= 1'b1;
    end
  end

  // Single-slot output register; holds while the FIFO stalls.
  always_ff @(posedge in_clk or negedge rst_l) begin
    if (!rst_l) begin
      out_q <= '0;
      out_v <= 1'b0;
    end else if (take) begin
      out_q <= '{data: data_v[grant], sop: req_sop[grant], eop: req_eop[grant],
                 empty: empty_v[grant]};
      out_v <= 1'b1;
    end else if (out_ready) begin
      out_v <= 1'b0;
    end
  end

  // Per-port count of forwarded EOPs, wrapping.
  always_ff @(posedge in_clk or negedge rst_l) begin
    if (!rst_l)        cnt        <= '0;
    else if (take_eop) cnt[grant] <= cnt[grant] + CNT_W'(1);
  end

  assign out_data   = out_q.data;
  assign out_sop    = out_q.sop;
  assign out_eop    = out_q.eop;
  assign out_empty  = out_q.empty;
  assign out_valid  = out_v;
  assign grant_port = grant;
  assign pkt_count  = cnt;

endmodule

// File: tb/tb_pkt_fifo_arbiter.sv
// Scoreboard bench for pkt_fifo_arbiter: per-port source queues, expected
// output queue filled in arbitration order, monitor pops on each transfer.
module tb_pkt_fifo_arbiter;

  localparam int NP = 4, DW = 512, EW = 6, CW = 32;

  logic              in_clk = 1'b0;
  logic              rst_l;
  logic [NP*DW-1:0]  req_data;
  logic [NP-1:0]     req_valid, req_ready, req_sop, req_eop;
  logic [NP*EW-1:0]  req_empty;
  logic [DW-1:0]     out_data;
  logic              out_valid, out_ready, out_sop, out_eop;
  logic [EW-1:0]     out_empty;
  logic              fifo_almost_full;
  logic [1:0]        grant_port;
  logic [NP*CW-1:0]  pkt_count;
  logic              proto_err;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_s;

  beat_s       src_q [NP][$];
  beat_s       exp_q [$];
  beat_s       mon_e;
  logic [31:0] exp_cnt [NP];
  logic [NP-1:0] took;
  int checks = 0, errors = 0;
  int cyc = 0, n_out = 0, last_eop_cyc = 0, last_gap = 0;

  pkt_fifo_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)) dut (
    .in_clk(in_clk), .rst_l(rst_l),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .req_sop(req_sop), .req_eop(req_eop), .req_empty(req_empty),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .fifo_almost_full(fifo_almost_full), .grant_port(grant_port),
    .pkt_count(pkt_count), .proto_err(proto_err)
  );

  always #5 in_clk = ~in_clk;

  // Sources: present queue heads at negedge, pop what was accepted.
  initial begin
    req_valid = '0; req_sop = '0; req_eop = '0; req_data = '0; req_empty = '0;
    took = '0;
    forever begin
      @(negedge in_clk);
      for (int p = 0; p < NP; p++) begin
        if (took[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() > 0) begin
          req_valid[p]          = 1'b1;
          req_sop[p]            = src_q[p][0].sop;
          req_eop[p]            = src_q[p][0].eop;
          req_data[p*DW +: DW]  = src_q[p][0].data;
          req_empty[p*EW +: EW] = src_q[p][0].empty;
        end else begin
          req_valid[p]          = 1'b0;
          req_sop[p]            = 1'b0;
          req_eop[p]            = 1'b0;
          req_data[p*DW +: DW]  = '0;
          req_empty[p*EW +: EW] = '0;
        end
      end
      #1;
      took = req_valid & req_ready;
    end
  end

  // Monitor: every output transfer must match the scoreboard head.
  initial begin
    forever begin
      @(negedge in_clk);
      #1;
      cyc++;
      if (rst_l && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got tag %h, expected no beat", out_data[31:0]);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e.data || out_sop !== mon_e.sop ||
              out_eop !== mon_e.eop || out_empty !== mon_e.empty) begin
            errors++;
            $display("FAIL beat: got tag %h sop %b eop %b empty %0d, expected tag %h sop %b eop %b empty %0d",
                     out_data[31:0], out_sop, out_eop, out_empty,
                     mon_e.data[31:0], mon_e.sop, mon_e.eop, mon_e.empty);
          end
        end
        n_out++;
        if (out_sop) last_gap = cyc - last_eop_cyc;
        if (out_eop) last_eop_cyc = cyc;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic push_pkt(input int port, input int id, input int n,
                          input bit to_src, input bit to_exp, input bit sop_ok);
    beat_s b;
    logic [31:0] tag;
    for (int i = 0; i < n; i++) begin
      tag     = {8'(port), 8'(id), 8'(i), 8'hA5};
      b.data  = {16{tag}};
      b.sop   = (i == 0) && sop_ok;
      b.eop   = (i == n - 1);
      b.empty = 6'(id + i);
      if (to_src) src_q[port].push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
    if (to_exp) exp_cnt[port]++;
  endtask

  task automatic drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge in_clk);
      #2;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_beats(input int target, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge in_clk);
      #2;
      if (n_out >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic flush_model();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_cnt[p] = '0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    rst_l = 1'b0;
    flush_model();
    step(2);
    rst_l = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    step(2);
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got v/s/e %b%b%b, expected 000", out_valid, out_sop, out_eop);
    end
    checks++;
    if (out_data !== '0 || out_empty !== '0) begin
      errors++; $display("FAIL reset_data: got tag %h empty %0d, expected 0", out_data[31:0], out_empty);
    end
    checks++;
    if (req_ready !== '0 || grant_port !== 2'd0) begin
      errors++; $display("FAIL reset_grant: got ready %b port %0d, expected 0", req_ready, grant_port);
    end
    checks++;
    if (pkt_count !== '0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL reset_stats: got count %h err %b, expected 0", pkt_count[31:0], proto_err);
    end
    @(negedge in_clk);
    rst_l = 1'b1;
    step(2);
  endtask

  task automatic test_two_ports();
    bit ok;
    push_pkt(0, 1, 3, 1, 1, 1);
    push_pkt(2, 1, 3, 1, 1, 1);
    drain(100, ok);
    step(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL two_ports_drain: got %0d beats left, expected 0", exp_q.size()); end
    checks++;
    if (last_gap !== 2) begin errors++; $display("FAIL two_ports_bubble: got eop->sop %0d cycles, expected 2", last_gap); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (pkt_count[p*CW +: CW] !== exp_cnt[p]) begin
        errors++; $display("FAIL two_ports_count%0d: got %0d, expected %0d", p, pkt_count[p*CW +: CW], exp_cnt[p]);
      end
    end
  endtask

  task automatic test_rr_stream();
    bit ok;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_pkt(p, 10 + r, 1, 1, 1, 1);
    drain(100, ok);
    step(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_drain: got %0d beats left, expected 0", exp_q.size()); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (pkt_count[p*CW +: CW] !== exp_cnt[p]) begin
        errors++; $display("FAIL rr_count%0d: got %0d, expected %0d", p, pkt_count[p*CW +: CW], exp_cnt[p]);
      end
    end
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL rr_proto: got %b, expected 0", proto_err); end
  endtask

  task automatic test_afull_idle();
    bit ok;
    @(negedge in_clk);
    fifo_almost_full = 1'b1;
    push_pkt(1, 20, 2, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk);
      #2;
      checks++;
      if (req_ready !== '0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL afull_hold: got ready %b valid %b, expected 0", req_ready, out_valid);
      end
    end
    @(negedge in_clk);
    fifo_almost_full = 1'b0;
    @(negedge in_clk);
    #2;
    checks++;
    if (grant_port !== 2'd1 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL afull_release: got port %0d ready %b, expected 1 0010", grant_port, req_ready);
    end
    drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL afull_idle_drain: got %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_afull_mid();
    bit ok;
    int base;
    base = n_out;
    push_pkt(0, 21, 5, 1, 1, 1);
    wait_beats(base + 2, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL afull_mid_start: got %0d beats, expected %0d", n_out - base, 2); end
    @(negedge in_clk);
    fifo_almost_full = 1'b1;
    push_pkt(2, 22, 1, 1, 0, 1);
    drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL afull_mid_drain: got %0d beats left, expected 0", exp_q.size()); end
    step(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk);
      #2;
      checks++;
      if (req_ready !== '0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL afull_mid_block: got ready %b valid %b, expected 0", req_ready, out_valid);
      end
    end
    checks++;
    if (src_q[2].size() != 1) begin errors++; $display("FAIL afull_mid_pending: got %0d beats queued, expected 1", src_q[2].size()); end
    push_pkt(2, 22, 1, 0, 1, 1);
    @(negedge in_clk);
    fifo_almost_full = 1'b0;
    drain(50, ok);
    step(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL afull_mid_resume: got %0d beats left, expected 0", exp_q.size()); end
    checks++;
    if (pkt_count[0 +: CW] !== exp_cnt[0]) begin
      errors++; $display("FAIL afull_mid_count: got %0d, expected %0d", pkt_count[0 +: CW], exp_cnt[0]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    logic [DW-1:0] sd;
    logic ss, se;
    logic [EW-1:0] sm;
    base = n_out;
    push_pkt(1, 30, 5, 1, 1, 1);
    wait_beats(base + 2, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_start: got %0d beats, expected 2", n_out - base); end
    @(negedge in_clk);
    out_ready = 1'b0;
    #2;
    sd = out_data; ss = out_sop; se = out_eop; sm = out_empty;
    checks++;
    if (out_valid !== 1'b1 || req_ready !== '0) begin
      errors++; $display("FAIL bp_stall: got valid %b ready %b, expected 1 0000", out_valid, req_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge in_clk);
      #2;
      checks++;
      if (out_data !== sd || out_sop !== ss || out_eop !== se || out_empty !== sm ||
          out_valid !== 1'b1 || req_ready !== '0) begin
        errors++; $display("FAIL bp_stable: got tag %h ready %b, expected tag %h ready 0000", out_data[31:0], req_ready, sd[31:0]);
      end
    end
    @(negedge in_clk);
    out_ready = 1'b1;
    drain(50, ok);
    step(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain: got %0d beats left, expected 0", exp_q.size()); end
    checks++;
    if (pkt_count[1*CW +: CW] !== exp_cnt[1]) begin
      errors++; $display("FAIL bp_count: got %0d, expected %0d", pkt_count[1*CW +: CW], exp_cnt[1]);
    end
  endtask

  task automatic test_proto_err();
    bit ok;
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clean: got %b, expected 0", proto_err); end
    push_pkt(3, 40, 1, 1, 0, 0);
    step(3);
    #2;
    checks++;
    if (proto_err !== 1'b1 || req_ready !== '0) begin
      errors++; $display("FAIL proto_set: got err %b ready %b, expected 1 0000", proto_err, req_ready);
    end
    src_q[3].delete();
    step(2);
    push_pkt(0, 41, 2, 1, 1, 1);
    drain(50, ok);
    checks++;
    if (!ok || proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_sticky: got err %b drained %b, expected 1 1", proto_err, ok);
    end
    do_reset();
    #2;
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_reset: got %b, expected 0", proto_err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    push_pkt(1, 50, 1, 1, 1, 1);
    drain(50, ok);
    base = n_out;
    push_pkt(2, 51, 4, 1, 1, 1);
    wait_beats(base + 2, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_start: got %0d beats, expected 2", n_out - base); end
    @(negedge in_clk);
    #2;
    rst_l = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_data !== '0 || out_empty !== '0) begin
      errors++; $display("FAIL rstmid_out: got valid %b tag %h, expected 0", out_valid, out_data[31:0]);
    end
    checks++;
    if (req_ready !== '0 || grant_port !== 2'd0 || pkt_count !== '0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: got ready %b port %0d count %h, expected 0", req_ready, grant_port, pkt_count[63:0]);
    end
    flush_model();
    step(2);
    rst_l = 1'b1;
    step(2);
    push_pkt(0, 52, 2, 1, 1, 1);
    push_pkt(2, 53, 2, 1, 1, 1);
    drain(50, ok);
    step(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_order: got %0d beats left, expected 0", exp_q.size()); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (pkt_count[p*CW +: CW] !== exp_cnt[p]) begin
        errors++; $display("FAIL rstmid_count%0d: got %0d, expected %0d", p, pkt_count[p*CW +: CW], exp_cnt[p]);
      end
    end
  endtask

  initial begin
    rst_l = 1'b0;
    out_ready = 1'b1;
    fifo_almost_full = 1'b0;
    for (int p = 0; p < NP; p++) exp_cnt[p] = '0;
    test_reset();
    test_two_ports();
    test_rr_stream();
    test_afull_idle();
    test_afull_mid();
    test_backpressure();
    test_proto_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
